// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller for the asynchronous FIFO (write clock domain).
// Optional macro FIFO_WR_OVF_STICKY_EN makes overflow a sticky flag cleared by ovf_clr.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    input  logic                  ovf_clr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_gray;
    logic [PW-1:0] wr_bin_next;
    logic [PW-1:0] wr_gray_next;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] level_next;
    logic [PW:0]   free_next;
    logic          full_next;
    logic          afull_next;
    logic          refused;
    logic          ovf_next;

    // Reset also gates the strobe so nothing reaches memory while held in reset.
    assign mem_we  = wr_en & ~full & rst;
    assign refused = wr_en & full;

    assign wr_addr     = wr_bin[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wr_gray;

    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rd_bin[i] = ^(rd_ptr_gray_sync >> i);
        end
    end

    always_comb begin
        wr_bin_next  = wr_bin + {{(PW-1){1'b0}}, mem_we};
        wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
        full_next    = (wr_gray_next == {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]});
        level_next   = wr_bin_next - rd_bin;
        free_next    = (PW+1)'(DEPTH) - {1'b0, level_next};
        afull_next   = (free_next <= (PW+1)'(AFULL_TH));
    end

`ifdef FIFO_WR_OVF_STICKY_EN
    // A refusal in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_next = overflow;
        if (refused) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_next       = refused;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bin      <= '0;
            wr_gray     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_bin      <= wr_bin_next;
            wr_gray     <= wr_gray_next;
            full        <= full_next;
            almost_full <= afull_next;
            wr_level    <= level_next;
            overflow    <= ovf_next;
        end
    end

endmodule
